// File: rtl/mips_muldiv_pkg.sv
// Shared MIPS core definitions: ALU, load/store selects and the
// multiply/divide unit's operation and state encodings.
package mips_muldiv_pkg;

    // ALU operation select driven by decode.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    // Load width / extension select.
    typedef enum logic [2:0] {
        LOAD_B  = 3'd0,
        LOAD_BU = 3'd1,
        LOAD_H  = 3'd2,
        LOAD_HU = 3'd3,
        LOAD_W  = 3'd4
    } load_e;

    // Store width select.
    typedef enum logic [1:0] {
        STORE_B = 2'd0,
        STORE_H = 2'd1,
        STORE_W = 2'd2
    } store_e;

    // Multiply/divide operation select. Bit 0 set means unsigned,
    // bit 1 set means divide.
    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    // Multiply/divide control states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Index of the final iteration in RUN (32 iterations total).
    localparam logic [4:0] MD_LAST_ITER = 5'd31;

    // Magnitude of a 32-bit value; treated as unsigned when is_signed=0.
    // The most negative value maps to 32'h8000_0000, which is its correct
    // unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mips_muldiv_iter.sv
// 64-bit iterative shift/accumulate datapath shared by multiply and divide.
// Multiply: acc = {partial, multiplier}; each step conditionally adds the
// multiplicand to the upper half and shifts right by one.
// Divide: acc = {remainder, quotient}; each step shifts left by one and
// performs a restoring subtract of the divisor.
module mips_muldiv_iter (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] acc
);
    import mips_muldiv_pkg::*;

    logic [63:0] acc_reg;
    logic [63:0] acc_next;
    logic [31:0] opnd_reg;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;

    // One multiply step and one restoring-divide step, selected by op kind.
    always_comb begin
        mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
        mul_next = {mul_sum, acc_reg[31:1]};

        // Remainder stays below the divisor, so the shifted value fits in
        // 33 bits and the difference (when taken) fits in 32.
        div_shift = {acc_reg[63:32], acc_reg[31]};
        div_ge    = (div_shift >= {1'b0, opnd_reg});
        div_diff  = div_shift[31:0] - opnd_reg;
        if (div_ge) begin
            div_next = {div_diff, acc_reg[30:0], 1'b1};
        end else begin
            div_next = {div_shift[31:0], acc_reg[30:0], 1'b0};
        end

        acc_next = is_div ? div_next : mul_next;
    end

    // Accumulator and fixed operand registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            acc_reg  <= 64'd0;
            opnd_reg <= 32'd0;
        end else if (load) begin
            acc_reg  <= {32'd0, a};
            opnd_reg <= b;
        end else if (step) begin
            acc_reg  <= acc_next;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/mips_muldiv_ctrl.sv
// MIPS HI/LO multiply/divide unit: IDLE/RUN/FIX control, iteration
// counter, operand capture, sign correction, HI/LO registers and the
// pipeline stall interlock.
module mips_muldiv_ctrl (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        op_valid,
    input  logic [1:0]  op_sel,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hi_en,
    input  logic        lo_en,
    input  logic        mf_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);
    import mips_muldiv_pkg::*;

    md_state_e   state_reg;
    md_state_e   state_next;
    logic [4:0]  iter_cnt_reg;
    logic [4:0]  iter_cnt_next;

    logic        accept;
    logic        step;
    logic        commit;
    logic        mthi_we;
    logic        mtlo_we;

    md_op_e      op_reg;
    logic [31:0] rs_raw_reg;
    logic        rt_neg_reg;
    logic        div_zero_reg;

    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        sel_signed;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [63:0] acc;

    logic        op_signed;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] hi_fix;
    logic [31:0] lo_fix;

    // State and iteration counter registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg    <= MD_IDLE;
            iter_cnt_reg <= 5'd0;
        end else begin
            state_reg    <= state_next;
            iter_cnt_reg <= iter_cnt_next;
        end
    end

    // Next state, counter and datapath/register control strobes.
    always_comb begin
        state_next    = state_reg;
        iter_cnt_next = iter_cnt_reg;
        accept        = 1'b0;
        step          = 1'b0;
        commit        = 1'b0;
        mthi_we       = 1'b0;
        mtlo_we       = 1'b0;
        case (state_reg)
            MD_IDLE: begin
                if (op_valid) begin
                    // A new operation takes priority over MTHI/MTLO.
                    accept        = 1'b1;
                    iter_cnt_next = 5'd0;
                    state_next    = MD_RUN;
                end else begin
                    mthi_we = hi_en;
                    mtlo_we = lo_en;
                end
            end
            MD_RUN: begin
                step          = 1'b1;
                iter_cnt_next = iter_cnt_reg + 5'd1;
                if (iter_cnt_reg == MD_LAST_ITER) begin
                    state_next = MD_FIX;
                end
            end
            MD_FIX: begin
                commit     = 1'b1;
                state_next = MD_IDLE;
            end
            default: begin
                state_next    = MD_IDLE;
                iter_cnt_next = 5'd0;
            end
        endcase
    end

    // Operand magnitudes fed to the datapath at acceptance.
    always_comb begin
        sel_signed = ~op_sel[0];
        a_abs      = abs32(rs_data, sel_signed);
        b_abs      = abs32(rt_data, sel_signed);
    end

    // Capture operation and sign information on the accept edge; later
    // changes of op_sel/rs_data/rt_data are ignored until the next accept.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            op_reg       <= MD_MULT;
            rs_raw_reg   <= 32'd0;
            rt_neg_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
        end else if (accept) begin
            op_reg       <= md_op_e'(op_sel);
            rs_raw_reg   <= rs_data;
            rt_neg_reg   <= rt_data[31];
            div_zero_reg <= (rt_data == 32'd0);
        end
    end

    mips_muldiv_iter u_iter (
        .clk    (clk),
        .rst_b  (rst_b),
        .load   (accept),
        .step   (step),
        .is_div (op_reg[1]),
        .a      (a_abs),
        .b      (b_abs),
        .acc    (acc)
    );

    // Sign correction of the unsigned result, plus divide-by-zero override.
    always_comb begin
        op_signed = ~op_reg[0];
        a_neg     = op_signed & rs_raw_reg[31];
        b_neg     = op_signed & rt_neg_reg;
        prod_fix  = (a_neg ^ b_neg) ? (~acc + 64'd1) : acc;
        quo_fix   = (a_neg ^ b_neg) ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix   = a_neg ? (~acc[63:32] + 32'd1) : acc[63:32];
        hi_fix    = prod_fix[63:32];
        lo_fix    = prod_fix[31:0];
        if (op_reg[1]) begin
            if (div_zero_reg) begin
                hi_fix = rs_raw_reg;
                lo_fix = 32'hFFFF_FFFF;
            end else begin
                hi_fix = rem_fix;
                lo_fix = quo_fix;
            end
        end
    end

    // HI/LO: result written on the FIX->IDLE edge, MTHI/MTLO only in IDLE.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hi_reg <= 32'd0;
            lo_reg <= 32'd0;
        end else if (commit) begin
            hi_reg <= hi_fix;
            lo_reg <= lo_fix;
        end else begin
            if (mthi_we) begin
                hi_reg <= rs_data;
            end
            if (mtlo_we) begin
                lo_reg <= rs_data;
            end
        end
    end

    assign hi    = hi_reg;
    assign lo    = lo_reg;
    assign busy  = (state_reg != MD_IDLE);
    assign stall = busy & (op_valid | hi_en | lo_en | mf_req);

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Directed bench for mips_muldiv_ctrl: reset, MTHI/MTLO, signed/unsigned
// multiply and divide, divide-by-zero, stall interlock and mid-op reset.
module tb_mips_muldiv_ctrl;

    logic        clk;
    logic        rst_b;
    logic        op_valid;
    logic [1:0]  op_sel;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_en;
    logic        lo_en;
    logic        mf_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    mips_muldiv_ctrl dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .op_valid (op_valid),
        .op_sel   (op_sel),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .hi_en    (hi_en),
        .lo_en    (lo_en),
        .mf_req   (mf_req),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Issue one op for a single cycle, scramble inputs afterwards, count
    // busy cycles, confirm HI/LO hold until the final edge, check result.
    task automatic run_op(input string tag, input logic [1:0] sel,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic mt_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi0;
        logic [31:0] lo0;
        int bc;
        int chg;
        @(negedge clk);
        hi0      = hi;
        lo0      = lo;
        op_valid = 1'b1;
        op_sel   = sel;
        rs_data  = a;
        rt_data  = b;
        lo_en    = mt_lo;
        @(negedge clk);
        op_valid = 1'b0;
        lo_en    = 1'b0;
        op_sel   = 2'($urandom);
        rs_data  = $urandom;
        rt_data  = $urandom;
        bc  = 0;
        chg = 0;
        while (busy && bc < 100) begin
            bc++;
            if (hi !== hi0 || lo !== lo0) chg++;
            @(negedge clk);
        end
        check_eq({tag, " busy_cycles"}, 64'(bc), 64'd33);
        check_eq({tag, " hilo_hold"}, 64'(chg), 64'd0);
        check_eq({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check_eq({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
        $display("%s: sel=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", tag, sel, a, b, hi, lo, bc);
    endtask

    initial begin
        int sc;
        int bc;
        rst_b    = 1'b0;
        op_valid = 1'b0;
        op_sel   = 2'd0;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        hi_en    = 1'b0;
        lo_en    = 1'b0;
        mf_req   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("reset hi", {32'd0, hi}, 64'd0);
        check_eq("reset lo", {32'd0, lo}, 64'd0);
        check_eq("reset busy", {63'd0, busy}, 64'd0);
        check_eq("reset stall", {63'd0, stall}, 64'd0);
        $display("reset: hi=%h lo=%h busy=%b stall=%b", hi, lo, busy, stall);
        rst_b  = 1'b1;
        mf_req = 1'b0;

        // MTHI then MTLO in IDLE
        @(negedge clk);
        hi_en   = 1'b1;
        rs_data = 32'h1234_5678;
        @(negedge clk);
        hi_en = 1'b0;
        check_eq("mthi", {32'd0, hi}, 64'h1234_5678);
        $display("mthi: rs=12345678 -> hi=%h", hi);
        lo_en   = 1'b1;
        rs_data = 32'hA5A5_A5A5;
        @(negedge clk);
        lo_en = 1'b0;
        check_eq("mtlo", {32'd0, lo}, 64'hA5A5_A5A5);
        $display("mtlo: rs=a5a5a5a5 -> lo=%h", lo);

        // Op with coincident MTLO: op wins, MTLO dropped
        run_op("multu_vs_mtlo", OP_MULTU, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
               32'hFFFF_FFFE, 32'h0000_0001);

        // MULT -3 x 7 with mf_req and a held MTHI arriving 5 cycles in
        @(negedge clk);
        op_valid = 1'b1;
        op_sel   = OP_MULT;
        rs_data  = 32'hFFFF_FFFD;
        rt_data  = 32'd7;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        mf_req  = 1'b1;
        hi_en   = 1'b1;
        rs_data = 32'hDEAD_BEEF;
        #1;
        sc = 0;
        while (stall && sc < 100) begin
            sc++;
            @(negedge clk);
        end
        check_eq("mf stall_cycles", 64'(sc), 64'd29);
        check_eq("mf stall_after", {63'd0, stall}, 64'd0);
        check_eq("mult hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check_eq("mult lo", {32'd0, lo}, 64'hFFFF_FFEB);
        $display("mult_stall: -3 x 7 -> hi=%h lo=%h stall_cycles=%0d", hi, lo, sc);
        mf_req = 1'b0;
        hi_en  = 1'b0;

        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 1'b0, 32'd7, 32'hFFFF_FFFF);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
        run_op("div_negdiv", OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0, 32'd2, 32'hFFFF_FFF2);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b0, 32'hF, 32'h0FFF_FFFF);

        // Reset at iteration 16 of MULTU 5 x 6
        @(negedge clk);
        op_valid = 1'b1;
        op_sel   = OP_MULTU;
        rs_data  = 32'd5;
        rt_data  = 32'd6;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (16) @(negedge clk);
        mf_req = 1'b1;
        rst_b  = 1'b0;
        #1;
        check_eq("midrst hi", {32'd0, hi}, 64'd0);
        check_eq("midrst lo", {32'd0, lo}, 64'd0);
        check_eq("midrst busy", {63'd0, busy}, 64'd0);
        check_eq("midrst stall", {63'd0, stall}, 64'd0);
        $display("mid_reset: hi=%h lo=%h busy=%b stall=%b", hi, lo, busy, stall);
        @(negedge clk);
        rst_b    = 1'b1;
        mf_req   = 1'b0;
        op_valid = 1'b1;
        op_sel   = OP_MULTU;
        rs_data  = 32'd5;
        rt_data  = 32'd6;
        @(negedge clk);
        op_valid = 1'b0;
        check_eq("postrst accept", {63'd0, busy}, 64'd1);
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        check_eq("postrst busy_cycles", 64'(bc), 64'd33);
        check_eq("postrst hi", {32'd0, hi}, 64'd0);
        check_eq("postrst lo", {32'd0, lo}, 64'd30);
        $display("post_reset: 5 x 6 -> hi=%h lo=%h busy_cycles=%0d", hi, lo, bc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
